// File: rtl/fold_mod_reducer.sv
// fold_mod_reducer
//   Iterative modular reducer: Q = P mod M for a 2*W-bit product P and a
//   runtime modulus M = 2^W - C with C < 2^C_W. The high half of the
//   accumulator is repeatedly folded onto the low half
//   (acc = acc[W-1:0] + acc[2W-1:W]*C), one fold per cycle, until the high
//   half is zero. MAX_FOLDS bounds the loop; hitting it flags out_err.
//
//   Optional feature macro: MODRED_FINAL_SUB_EN
//     defined   - a final conditional subtraction of M makes Q canonical
//                 in [0, M) (extra SUB state, one more cycle).
//     undefined - Q is lazily reduced: Q < 2^W and Q == P (mod M).
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   P/mod_m/mod_c presented
//   in_ready   block idle, accepts an operand
//   P          2*W-bit product to reduce
//   mod_m      W-bit modulus M (M[W-1] = 1)
//   mod_c      C_W-bit fold constant C = 2^W - M
//   Q          W-bit result
//   out_valid  Q valid, held until out_ready
//   out_ready  downstream accepts Q
//   out_err    fold bound exceeded for this result (qualified by out_valid)
module fold_mod_reducer #(
  parameter int W         = 256,
  parameter int C_W       = 128,
  parameter int MAX_FOLDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   P,
  input  logic [W-1:0]     mod_m,
  input  logic [C_W-1:0]   mod_c,
  output logic [W-1:0]     Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err
);

  localparam int CNT_W = $clog2(MAX_FOLDS + 1);

`ifdef MODRED_FINAL_SUB_EN
  typedef enum logic [1:0] {IDLE, FOLD, SUB, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fold_cnt;
  logic [2*W-1:0]   acc;
  logic [C_W-1:0]   c_reg;
  logic [W-1:0]     acc_hi, acc_lo;
  logic [2*W-1:0]   fold_sum;
  logic             hi_zero, cnt_max, fold_exit;

`ifdef MODRED_FINAL_SUB_EN
  logic [W-1:0]     m_reg;
  logic             err;

  // Single subtraction is enough: acc_lo < 2^W and 2^W - M < M.
  function automatic logic [W-1:0] cond_sub(input logic [W-1:0] x,
                                            input logic [W-1:0] m);
    return (x >= m) ? x - m : x;
  endfunction
`else
  // Modulus is only needed by the final subtraction.
  logic unused_mod_m;
  assign unused_mod_m = ^mod_m;
`endif

  assign in_ready  = (state == IDLE);
  assign acc_hi    = acc[2*W-1:W];
  assign acc_lo    = acc[W-1:0];
  assign hi_zero   = (acc_hi == '0);
  assign cnt_max   = (fold_cnt == CNT_W'(MAX_FOLDS));
  assign fold_exit = hi_zero || cnt_max;

  // hi*C is at most W+C_W <= 3W/2 bits, so the full sum fits in 2W bits.
  assign fold_sum = {{W{1'b0}}, acc_lo}
                  + ({{W{1'b0}}, acc_hi} * {{(2*W-C_W){1'b0}}, c_reg});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = FOLD;
`ifdef MODRED_FINAL_SUB_EN
      FOLD: if (fold_exit) state_nxt = SUB;
      SUB:  state_nxt = DONE;
`else
      FOLD: if (fold_exit) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fold_cnt  <= '0;
      Q         <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
`ifdef MODRED_FINAL_SUB_EN
      err       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            fold_cnt <= '0;
`ifdef MODRED_FINAL_SUB_EN
            err      <= 1'b0;
`endif
          end
        end
        FOLD: begin
          if (!fold_exit) begin
            fold_cnt <= fold_cnt + CNT_W'(1);
          end else begin
`ifdef MODRED_FINAL_SUB_EN
            // Leaving with a nonzero high half means the bound was hit.
            err       <= !hi_zero;
`else
            Q         <= acc_lo;
            out_err   <= !hi_zero;
            out_valid <= 1'b1;
`endif
          end
        end
`ifdef MODRED_FINAL_SUB_EN
        SUB: begin
          Q         <= cond_sub(acc_lo, m_reg);
          out_err   <= err;
          out_valid <= 1'b1;
        end
`endif
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Operand / accumulator datapath (no reset needed)
  always_ff @(posedge clock) begin
    if (state == IDLE && in_valid) begin
      acc   <= P;
      c_reg <= mod_c;
`ifdef MODRED_FINAL_SUB_EN
      m_reg <= mod_m;
`endif
    end else if (state == FOLD && !fold_exit) begin
      acc <= fold_sum;
    end
  end

endmodule

// File: tb/tb_fold_mod_reducer.sv
module tb_fold_mod_reducer;

  localparam int W   = 16;
  localparam int C_W = 8;
`ifdef MODRED_FINAL_SUB_EN
  localparam int LAT0 = 2;
`else
  localparam int LAT0 = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sel = 1'b0;
  logic [2*W-1:0] p = '0;
  logic [W-1:0]  mod_m = 16'hFFF1;
  logic [C_W-1:0] mod_c = 8'h0F;

  logic          in_valid_a, in_valid_b;
  logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic          out_err_a, out_err_b;
  logic [W-1:0]  q_a, q_b;
  logic          in_ready, out_valid, out_err;
  logic [W-1:0]  q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign in_valid_a = in_valid && !sel;
  assign in_valid_b = in_valid && sel;
  assign in_ready   = sel ? in_ready_b  : in_ready_a;
  assign out_valid  = sel ? out_valid_b : out_valid_a;
  assign out_err    = sel ? out_err_b   : out_err_a;
  assign q          = sel ? q_b         : q_a;

  fold_mod_reducer #(.W(W), .C_W(C_W), .MAX_FOLDS(4)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .P(p), .mod_m(mod_m), .mod_c(mod_c), .Q(q_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_err(out_err_a)
  );

  fold_mod_reducer #(.W(W), .C_W(C_W), .MAX_FOLDS(2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .P(p), .mod_m(mod_m), .mod_c(mod_c), .Q(q_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_err(out_err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: fold with plain integer arithmetic; canonical result is P % M.
  task automatic ref_model(input longint unsigned pv, input longint unsigned mv,
                           input longint unsigned cv, input int maxf,
                           output longint unsigned qv, output int k, output bit e);
    longint unsigned a, hi, lo;
    a = pv; k = 0; e = 1'b0;
    while (1) begin
      hi = a >> W;
      if (hi == 0) break;
      if (k == maxf) begin e = 1'b1; break; end
      a = (a & 64'hFFFF) + hi * cv;
      k++;
    end
    lo = a & 64'hFFFF;
`ifdef MODRED_FINAL_SUB_EN
    qv = e ? ((lo >= mv) ? lo - mv : lo) : pv % mv;
`else
    qv = lo;
`endif
  endtask

  task automatic do_op(input bit s, input longint unsigned pv, input longint unsigned cv,
                       input int hold);
    longint unsigned mv, qv;
    int k, n, w;
    bit e;
    mv = 64'h10000 - cv;
    ref_model(pv, mv, cv, s ? 2 : 4, qv, k, e);
    sel = s;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clock); #1; w++; end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    p = pv[31:0]; mod_m = mv[15:0]; mod_c = cv[7:0]; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; p = $urandom; mod_m = 16'h8000 | 16'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      check("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clock); #1;
      n++;
    end
    check("latency", 64'(n), 64'(LAT0 + k));
    check("Q", 64'(q), qv);
    check("out_err", 64'(out_err), 64'(e));
`ifndef MODRED_FINAL_SUB_EN
    if (!e) check("Q_congruent", longint'(q) % mv, pv % mv);
`endif
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1)); p = $urandom;
      @(posedge clock); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_Q", 64'(q), qv);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("retire_valid", 64'(out_valid), 64'd0);
    check("retire_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready_a", 64'(in_ready_a), 64'd1);
    check("rst_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_Q_a", 64'(q_a), 64'd0);
    check("rst_err_a", 64'(out_err_a), 64'd0);
    check("rst_valid_b", 64'(out_valid_b), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed cases with M = 0xFFF1, C = 0x0F
    do_op(1'b0, 64'h00001234, 64'h0F, 0);
    do_op(1'b0, 64'hFFFFFFFF, 64'h0F, 0);
    do_op(1'b0, 64'h0000FFF1, 64'h0F, 0);
    do_op(1'b0, 64'h0000FFF5, 64'h0F, 0);
    do_op(1'b0, 64'hFFFFFFFF, 64'h0F, 5);
    do_op(1'b1, 64'hFFFFFFFF, 64'h0F, 2);

    // Reset in the middle of a fold sequence
    sel = 1'b0; p = 32'hFFFFFFFF; mod_m = 16'hFFF1; mod_c = 8'h0F; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid_a), 64'd0);
    check("midrst_in_ready", 64'(in_ready_a), 64'd1);
    check("midrst_Q", 64'(q_a), 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
    do_op(1'b0, 64'h00001234, 64'h0F, 0);

    // Randomized operands and moduli on both bound settings
    for (int i = 0; i < 60; i++) begin
      longint unsigned pv, cv;
      pv = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 65535)) : 64'($urandom);
      cv = 64'($urandom_range(1, 255));
      do_op(1'($urandom_range(0, 1)), pv, cv, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
